// File: rtl/simd_decoder.sv
// simd_decoder: instruction fetch/decode front end feeding one control word per datapath issue slot.
// Define SIMD_DECODER_PERF_EN to add the issued_count/bubble_count performance counters.
module simd_decoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int OP_SEL_WIDTH = 4,
  parameter int IMEM_AW = 8,
  localparam int INSTR_WIDTH = 6 + 3*ADDR_WIDTH,
  localparam int CTRL_WIDTH = 3*ADDR_WIDTH + OP_SEL_WIDTH + 4
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [IMEM_AW-1:0]     start_pc,
  output logic                   busy,
  output logic                   done,
  output logic                   imem_en,
  output logic [IMEM_AW-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   issue_slot,
  output logic [CTRL_WIDTH-1:0]  ctrl_word,
  output logic                   ctrl_valid
`ifdef SIMD_DECODER_PERF_EN
  ,
  output logic [31:0]            issued_count,
  output logic [31:0]            bubble_count
`endif
);
  logic [5:0] op;
  logic [ADDR_WIDTH-1:0] ra, aa, ba;
  logic [OP_SEL_WIDTH-1:0] pe;
  logic [CTRL_WIDTH-1:0] dec;
  logic [IMEM_AW-1:0] pc;
  logic in_flight, is_halt, accept, consume;
  assign {op, ra, aa, ba} = imem_rdata;
  assign pe = OP_SEL_WIDTH'(op[3:0]);
  assign is_halt = &op;
  // opcode[5:4]: 01 ELEM, 10 DOT_ACC (no result write), 11 DOT_WB; 00 stays all-zero
  assign dec = (op[5:4] == 2'b00) ? '0 :
               {aa, ba, pe, op[5], &op[5:4], {ADDR_WIDTH{op[4]}} & ra, op[4], &op[5:4]};
  assign accept = start && !busy && !done;
  assign consume = ctrl_valid && issue_slot;
  assign imem_en = busy && !in_flight && (!ctrl_valid || issue_slot);
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= 1'b0;
      done <= 1'b0;
      pc <= '0;
      in_flight <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl_word <= '0;
    end else begin
      done <= 1'b0;
      in_flight <= imem_en;
      if (accept) begin
        busy <= 1'b1;
        pc <= start_pc;
      end
      if (imem_en) pc <= pc + 1'b1;
      if (in_flight && is_halt) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      // a returning word always wins over the consume of the previous one
      if (in_flight && !is_halt) begin
        ctrl_valid <= 1'b1;
        ctrl_word <= dec;
      end else if (consume) begin
        ctrl_valid <= 1'b0;
        ctrl_word <= '0;
      end
    end
  end
`ifdef SIMD_DECODER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn || accept) begin
      issued_count <= '0;
      bubble_count <= '0;
    end else begin
      if (consume && !(&issued_count)) issued_count <= issued_count + 1'b1;
      if (issue_slot && busy && !ctrl_valid && !(&bubble_count)) bubble_count <= bubble_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_simd_decoder.sv
// tb_simd_decoder: random-program bench for simd_decoder against a program-level reference model.
module tb_simd_decoder;
  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [3:0] pe;
    logic       dp;
    logic       sh;
    logic [9:0] r;
    logic       we;
    logic       rs;
  } cw_t;
  logic clk, rstn, start, busy, done, imem_en, issue_slot, ctrl_valid;
  logic [7:0] start_pc, imem_addr;
  logic [35:0] imem_rdata;
  logic [37:0] ctrl_word;
  logic [35:0] mem [256];
  cw_t expq [$];
  logic [7:0] addrs [$];
  int vectors = 0, fails = 0;
  int n_words, bubbles, first_cv;
  logic [37:0] first_word;
`ifdef SIMD_DECODER_PERF_EN
  logic [31:0] issued_count, bubble_count;
`endif
  simd_decoder dut (
    .clk(clk), .rstn(rstn), .start(start), .start_pc(start_pc), .busy(busy), .done(done),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .issue_slot(issue_slot),
    .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid)
`ifdef SIMD_DECODER_PERF_EN
    , .issued_count(issued_count), .bubble_count(bubble_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [5:0] op, input logic [9:0] r, a, b);
    return {op, r, a, b};
  endfunction

  function automatic cw_t model(input logic [35:0] ins);
    cw_t w;
    int cls;
    w = '0;
    cls = int'(ins[35:34]);
    if (cls != 0) begin
      w.a = ins[19:10];
      w.b = ins[9:0];
      w.pe = ins[33:30];
      w.dp = cls >= 2;
      w.sh = cls == 3;
      w.we = cls != 2;
      w.rs = cls == 3;
      w.r = w.we ? ins[29:20] : 10'd0;
    end
    return w;
  endfunction

  task automatic load_rand(input logic [7:0] spc, input int n, input bit allow_nop);
    logic [7:0] p;
    p = spc;
    for (int i = 0; i < n; i++) begin
      mem[p] = mk(allow_nop ? 6'($urandom_range(0, 62)) : 6'($urandom_range(16, 62)),
                  10'($urandom), 10'($urandom), 10'($urandom));
      p = p + 8'd1;
    end
    mem[p] = {6'h3F, 30'($urandom)};
  endtask

  // mode 0: slot on odd cycles, 1: random slots, 2: odd cycles with slots withheld in cycles 3..8
  task automatic run_prog(input logic [7:0] spc, input int mode, input bit ign_start);
    logic [7:0] p;
    cw_t held;
    int cyc;
    bit done_seen;
    expq.delete();
    addrs.delete();
    p = spc;
    for (int i = 0; i < 256 && mem[p][35:30] != 6'h3F; i++) begin
      expq.push_back(model(mem[p]));
      p = p + 8'd1;
    end
    held = model(mem[spc]);
    n_words = 0; bubbles = 0; first_cv = -1; first_word = '1; done_seen = 0;
    start = 1'b1; start_pc = spc; issue_slot = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 400) begin
      issue_slot = (mode == 1) ? 1'($urandom_range(0, 1)) :
                   (mode == 2 && cyc >= 3 && cyc <= 8) ? 1'b0 : 1'(cyc & 1);
      if (ign_start && cyc == 4) begin
        start = 1'b1;
        start_pc = spc + 8'd3;
      end
      @(negedge clk);
      if (imem_en) addrs.push_back(imem_addr);
      if (ctrl_valid && first_cv < 0) first_cv = cyc;
      if (busy && issue_slot && !ctrl_valid) bubbles++;
      if (mode == 2 && cyc >= 3 && cyc <= 8) begin
        chk("hold valid", ctrl_valid, 1);
        chk("hold word", ctrl_word, held);
        chk("hold no fetch", imem_en, 0);
        chk("hold pc", imem_addr, spc + 8'd1);
      end
      if (ctrl_valid && issue_slot) begin
        if (n_words == 0) first_word = ctrl_word;
        if (expq.size() == 0) chk("extra word", ctrl_word, 38'h3F_FFFF_FFFF);
        else chk("word", ctrl_word, expq.pop_front());
        n_words++;
      end
      if (done) begin
        done_seen = 1;
        chk("busy low at done", busy, 0);
        chk("no word at done", ctrl_valid, 0);
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    chk("done seen", done_seen, 1);
    chk("words left", expq.size(), 0);
    start = 1'b1; start_pc = spc;
    @(posedge clk); #1;
    start = 1'b0; issue_slot = 1'b0;
    @(negedge clk);
    chk("start with done ignored", busy, 0);
    chk("done one cycle", done, 0);
`ifdef SIMD_DECODER_PERF_EN
    chk("perf issued", issued_count, n_words);
    chk("perf bubbles", bubble_count, bubbles);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) mem[i] = {6'h3F, 30'd0};
    rstn = 1'b0; start = 1'b0; start_pc = '0; issue_slot = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst imem_en", imem_en, 0);
    chk("rst valid", ctrl_valid, 0);
    chk("rst word", ctrl_word, 0);
    chk("rst pc", imem_addr, 0);
    @(posedge clk); #1;
    mem[5] = mk(6'h13, 10'd7, 10'd1, 10'd2);
    mem[6] = {6'h3F, 30'd0};
    run_prog(8'd5, 0, 0);
    chk("elem latency", first_cv, 3);
    chk("elem word", first_word, {10'd1, 10'd2, 4'h3, 1'b0, 1'b0, 10'd7, 1'b1, 1'b0});
    chk("elem fetches", addrs.size(), 2);
    chk("elem fetch0", addrs[0], 5);
    load_rand(8'd20, 8, 0);
    mem[24] = mk(6'h3A, 10'h155, 10'h0AA, 10'h3FF);
    run_prog(8'd20, 0, 0);
    chk("tput words", n_words, 8);
    chk("tput bubbles", bubbles, 1);
    load_rand(8'd40, 4, 1);
    run_prog(8'd40, 2, 0);
    chk("hold words", n_words, 4);
    mem[255] = 36'd0;
    mem[0] = {6'h3F, 30'd0};
    run_prog(8'd255, 0, 0);
    chk("wrap fetches", addrs.size(), 2);
    chk("wrap addr0", addrs[0], 255);
    chk("wrap addr1", addrs[1], 0);
    chk("wrap words", n_words, 1);
    chk("wrap nop word", first_word, 0);
    load_rand(8'd60, 3, 0);
    run_prog(8'd60, 0, 1);
    chk("busy-start words", n_words, 3);
    chk("busy-start bubbles", bubbles, 1);
    for (int t = 0; t < 5; t++) begin
      logic [7:0] s;
      s = 8'($urandom_range(80, 230));
      load_rand(s, $urandom_range(1, 12), 1);
      run_prog(s, 1, 0);
    end
    load_rand(8'd100, 6, 0);
    start = 1'b1; start_pc = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int c = 1; c < 50 && !hit; c++) begin
      issue_slot = 1'(c & 1);
      @(negedge clk);
      if (ctrl_valid && issue_slot && imem_en) begin
        hit = 1;
        rstn = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("reset point reached", hit, 1);
    rstn = 1'b1; issue_slot = 1'b0;
    @(negedge clk);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst imem_en", imem_en, 0);
    chk("mid rst valid", ctrl_valid, 0);
    chk("mid rst word", ctrl_word, 0);
    chk("mid rst pc", imem_addr, 0);
`ifdef SIMD_DECODER_PERF_EN
    chk("mid rst issued", issued_count, 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("stale data dropped", ctrl_valid, 0);
    chk("stale word zero", ctrl_word, 0);
    @(posedge clk); #1;
    load_rand(8'd130, 5, 1);
    run_prog(8'd130, 0, 0);
    chk("post-reset words", n_words, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
